ray_quadratic_setup: RTL and testbench

- Producer side of the sphere-intersection datapath. Takes one ray (origin, direction) and one sphere (centre, radius) in Q18.14.
- Computes the quadratic coefficients A = d·d, B = 2·d·(o−c), C = |o−c|² − r², and the discriminant B² − 4AC.
- Presents A, B, discriminant and a hit flag with a one-cycle valid pulse. Feeds square_q18 (discriminant) and RaySphereIntersector2 (A, B, hit).
- Sequential: one shared multiplier, driven by a step counter and FSM.

---
 rtl/rt_fixed_pkg.sv | 43 ++++
 rtl/fx_mul128.sv | 14 +
 rtl/ray_quadratic_setup.sv | 181 ++++++++++++++++++
 tb/tb_ray_quadratic_setup.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_fixed_pkg.sv
// Shared fixed-point types, FSM states and MUL-step indices for the ray/sphere setup datapath.
package rt_fixed_pkg;

    localparam int unsigned FRAC = 14;
    localparam int unsigned W    = 32;
    localparam int unsigned WW   = 64;
    localparam int unsigned PW   = 2 * WW;

    typedef logic signed [W-1:0]  q18_14_t;
    typedef logic signed [WW-1:0] q_wide_t;
    typedef logic signed [PW-1:0] q_prod_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_e;

    // MUL sequence: SA, SB, SL accumulate three products each, then SR, P, Q
    localparam logic [3:0] STEP_SA_LAST  = 4'd2;
    localparam logic [3:0] STEP_SB_FIRST = 4'd3;
    localparam logic [3:0] STEP_SB_LAST  = 4'd5;
    localparam logic [3:0] STEP_SL_FIRST = 4'd6;
    localparam logic [3:0] STEP_SL_LAST  = 4'd8;
    localparam logic [3:0] STEP_SR      = 4'd9;
    localparam logic [3:0] STEP_P       = 4'd10;
    localparam logic [3:0] STEP_Q       = 4'd11;

    // True when v does not fit in a signed WW-bit value
    function automatic logic is_ovf_ww(input q_prod_t v);
        return !((&v[PW-1:WW-1]) || !(|v[PW-1:WW-1]));
    endfunction

    function automatic q_wide_t sat_ww(input q_prod_t v);
        if (is_ovf_ww(v)) begin
            return v[PW-1] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
        end
        return v[WW-1:0];
    endfunction

endpackage

// File: rtl/fx_mul128.sv
// Combinational signed 64x64 multiplier with full 128-bit product.
module fx_mul128
    import rt_fixed_pkg::*;
(
    input  logic signed [WW-1:0] a,
    input  logic signed [WW-1:0] b,
    output logic signed [PW-1:0] p
);

    always_comb begin
        p = PW'(a) * PW'(b);
    end

endmodule

// File: rtl/ray_quadratic_setup.sv
// Sequential ray/sphere quadratic setup: A = d.d, B = 2 d.(o-c), discriminant = B^2 - 4AC,
// built from one shared 64x64 multiplier stepped through 12 products.
module ray_quadratic_setup
    import rt_fixed_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  ox,
    input  logic [W-1:0]  oy,
    input  logic [W-1:0]  oz,
    input  logic [W-1:0]  dx,
    input  logic [W-1:0]  dy,
    input  logic [W-1:0]  dz,
    input  logic [W-1:0]  cx,
    input  logic [W-1:0]  cy,
    input  logic [W-1:0]  cz,
    input  logic [W-1:0]  radius,
    output logic          busy,
    output logic          valid,
    output logic          hit,
    output logic [W-1:0]  A,
    output logic [WW-1:0] B,
    output logic [WW-1:0] discriminant,
    output logic          sat
);

    state_e state, state_next;
    logic [3:0] step;

    q18_14_t ox_q, oy_q, oz_q, dx_q, dy_q, dz_q, cx_q, cy_q, cz_q, r_q;
    logic signed [W:0] lx, ly, lz;
    q_prod_t sa, sb, sl, sr, p, q;
    q_wide_t a_int, b_int, c_int;

    q_wide_t mul_a, mul_b;
    q_prod_t prod;
    q_prod_t a_shr, b_shr, c_shr, d_full;
    q_wide_t a_sat;
    logic    a_clip;
    logic [W-1:0] a_out;

    fx_mul128 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    // Operand select for the shared multiplier
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step)
            4'd0:    begin mul_a = WW'(dx_q); mul_b = WW'(dx_q); end
            4'd1:    begin mul_a = WW'(dy_q); mul_b = WW'(dy_q); end
            4'd2:    begin mul_a = WW'(dz_q); mul_b = WW'(dz_q); end
            4'd3:    begin mul_a = WW'(dx_q); mul_b = WW'(lx);   end
            4'd4:    begin mul_a = WW'(dy_q); mul_b = WW'(ly);   end
            4'd5:    begin mul_a = WW'(dz_q); mul_b = WW'(lz);   end
            4'd6:    begin mul_a = WW'(lx);   mul_b = WW'(lx);   end
            4'd7:    begin mul_a = WW'(ly);   mul_b = WW'(ly);   end
            4'd8:    begin mul_a = WW'(lz);   mul_b = WW'(lz);   end
            4'd9:    begin mul_a = WW'(r_q);  mul_b = WW'(r_q);  end
            4'd10:   begin mul_a = b_int;     mul_b = b_int;     end
            4'd11:   begin mul_a = a_int;     mul_b = c_int;     end
            default: begin mul_a = '0;        mul_b = '0;        end
        endcase
    end

    // Rescaled intermediates at full product width, narrowed when registered
    always_comb begin
        a_shr  = sa >>> FRAC;
        b_shr  = (sb >>> FRAC) <<< 1;
        c_shr  = (sl - sr) >>> FRAC;
        d_full = (p >>> FRAC) - ((q >>> FRAC) <<< 2);
        a_sat  = sat_ww(a_shr);
        a_clip = a_sat[WW-1] | (|a_sat[WW-2:W-1]);
        if (a_sat[WW-1]) begin
            a_out = '0;
        end else if (a_clip) begin
            a_out = {1'b0, {(W-1){1'b1}}};
        end else begin
            a_out = a_sat[W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = MUL;
            MUL:     if (step == STEP_Q) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, accumulators and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            ox_q <= '0; oy_q <= '0; oz_q <= '0;
            dx_q <= '0; dy_q <= '0; dz_q <= '0;
            cx_q <= '0; cy_q <= '0; cz_q <= '0;
            r_q  <= '0;
            lx <= '0; ly <= '0; lz <= '0;
            sa <= '0; sb <= '0; sl <= '0; sr <= '0; p <= '0; q <= '0;
            a_int <= '0; b_int <= '0; c_int <= '0;
            busy <= 1'b0; valid <= 1'b0; hit <= 1'b0; sat <= 1'b0;
            A <= '0; B <= '0; discriminant <= '0;
        end else begin
            valid <= 1'b0;
            busy  <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ox_q <= q18_14_t'(ox); oy_q <= q18_14_t'(oy); oz_q <= q18_14_t'(oz);
                        dx_q <= q18_14_t'(dx); dy_q <= q18_14_t'(dy); dz_q <= q18_14_t'(dz);
                        cx_q <= q18_14_t'(cx); cy_q <= q18_14_t'(cy); cz_q <= q18_14_t'(cz);
                        r_q  <= q18_14_t'(radius);
                    end
                end
                LOAD: begin
                    lx <= (W+1)'(ox_q) - (W+1)'(cx_q);
                    ly <= (W+1)'(oy_q) - (W+1)'(cy_q);
                    lz <= (W+1)'(oz_q) - (W+1)'(cz_q);
                    sa <= '0; sb <= '0; sl <= '0; sr <= '0; p <= '0; q <= '0;
                    a_int <= '0; b_int <= '0; c_int <= '0;
                    step <= '0;
                    sat  <= 1'b0;
                    hit  <= 1'b0;
                    A <= '0; B <= '0; discriminant <= '0;
                end
                MUL: begin
                    step <= step + 4'd1;
                    if (step <= STEP_SA_LAST)      sa <= sa + prod;
                    else if (step <= STEP_SB_LAST) sb <= sb + prod;
                    else if (step <= STEP_SL_LAST) sl <= sl + prod;
                    else if (step == STEP_SR)      sr <= prod;
                    else if (step == STEP_P)       p  <= prod;
                    else                           q  <= prod;

                    // Each coefficient is narrowed on the step after its accumulator completes
                    if (step == STEP_SB_FIRST) begin
                        a_int <= a_sat;
                        A     <= a_out;
                        sat   <= sat | is_ovf_ww(a_shr) | a_clip;
                    end
                    if (step == STEP_SL_FIRST) begin
                        b_int <= sat_ww(b_shr);
                        B     <= sat_ww(b_shr);
                        sat   <= sat | is_ovf_ww(b_shr);
                    end
                    if (step == STEP_P) begin
                        c_int <= sat_ww(c_shr);
                        sat   <= sat | is_ovf_ww(c_shr);
                    end
                end
                FINAL: begin
                    discriminant <= sat_ww(d_full);
                    sat          <= sat | is_ovf_ww(d_full);
                end
                DONE: begin
                    valid <= 1'b1;
                    hit   <= ~discriminant[WW-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_quadratic_setup.sv
// Self-checking bench for ray_quadratic_setup against an arithmetic reference model.
module tb_ray_quadratic_setup;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic signed [31:0] ox, oy, oz, dx, dy, dz, cx, cy, cz, rad;
    logic busy, valid, hit, sat;
    logic [31:0] a_o;
    logic [63:0] b_o, disc_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_a;
    logic signed [63:0] exp_b, exp_d;
    logic exp_hit, exp_sat, ms;

    always #5 clk = ~clk;

    ray_quadratic_setup dut (
        .clk(clk), .rst(rst), .start(start),
        .ox(ox), .oy(oy), .oz(oz),
        .dx(dx), .dy(dy), .dz(dz),
        .cx(cx), .cy(cy), .cz(cz),
        .radius(rad),
        .busy(busy), .valid(valid), .hit(hit),
        .A(a_o), .B(b_o), .discriminant(disc_o), .sat(sat)
    );

    function automatic logic signed [63:0] sat64(input logic signed [127:0] v);
        logic signed [127:0] hi, lo;
        hi = 128'(64'sh7FFF_FFFF_FFFF_FFFF);
        lo = -hi - 128'sd1;
        if (v > hi) begin ms = 1'b1; return hi[63:0]; end
        if (v < lo) begin ms = 1'b1; return lo[63:0]; end
        return v[63:0];
    endfunction

    // Reference: the quadratic coefficients in plain wide arithmetic
    task automatic model();
        logic signed [32:0] lx, ly, lz;
        logic signed [127:0] sa, sb, sl, sr, p, q;
        logic signed [63:0] a64, b64, c64;
        ms = 1'b0;
        lx = ox - cx; ly = oy - cy; lz = oz - cz;
        sa = dx * dx + dy * dy + dz * dz;
        sb = dx * lx + dy * ly + dz * lz;
        sl = lx * lx + ly * ly + lz * lz;
        sr = rad * rad;
        a64 = sat64(sa >>> 14);
        if (a64 > 64'sd2147483647) begin exp_a = 32'h7FFF_FFFF; ms = 1'b1; end
        else exp_a = a64[31:0];
        b64 = sat64((sb >>> 14) <<< 1);
        c64 = sat64((sl - sr) >>> 14);
        p = b64 * b64;
        q = a64 * c64;
        exp_b = b64;
        exp_d = sat64((p >>> 14) - ((q >>> 14) <<< 2));
        exp_hit = (exp_d >= 0);
        exp_sat = ms;
    endtask

    task automatic set_in(input int o0, o1, o2, d0, d1, d2, c0, c1, c2, r);
        ox = o0; oy = o1; oz = o2; dx = d0; dy = d1; dz = d2;
        cx = c0; cy = c1; cz = c2; rad = r;
    endtask

    // Start one run, scramble inputs after the sample, return cycles to valid
    task automatic do_run(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom);
        lat = 0;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, hit, sat, a_o, b_o, disc_o} !== '0) begin
            failures++;
            $display("FAIL reset_in: got busy=%b valid=%b A=%0d B=%0d disc=%0d need all 0",
                     busy, valid, a_o, b_o, disc_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b valid=%b need 0 0", busy, valid);
        end
    endtask

    task automatic test_directed();
        int tbl[4][10];
        int lat;
        tbl[0] = '{0, 0, 0, 0, 0, -16384, 0, 0, -81920, 16384};
        tbl[1] = '{0, 0, 0, 0, 0, -16384, 49152, 0, -81920, 16384};
        tbl[2] = '{0, 0, 0, 0, 0, -16384, 16384, 0, -81920, 16384};
        tbl[3] = '{16384, 8192, 0, 11585, 5793, -11585, 49152, 16384, -32768, 40960};
        for (int i = 0; i < 4; i++) begin
            set_in(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5],
                   tbl[i][6], tbl[i][7], tbl[i][8], tbl[i][9]);
            model();
            do_run(lat);
            checks++;
            if (lat !== 15) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d need 15", i, lat);
            end
            checks++;
            if (a_o !== exp_a || b_o !== exp_b || disc_o !== exp_d || hit !== exp_hit || sat !== exp_sat) begin
                failures++;
                $display("FAIL dir%0d_model: got A=%0d B=%0d d=%0d hit=%b sat=%b need A=%0d B=%0d d=%0d hit=%b sat=%b",
                         i, a_o, $signed(b_o), $signed(disc_o), hit, sat, exp_a, exp_b, exp_d, exp_hit, exp_sat);
            end
        end
    endtask

    task automatic test_spec_values();
        int lat;
        longint dd;
        // Hit case literal values
        set_in(0, 0, 0, 0, 0, -16384, 0, 0, -81920, 16384);
        do_run(lat);
        checks++;
        if (a_o !== 32'd16384 || $signed(b_o) !== -64'sd163840 || $signed(disc_o) !== 64'sd65536
            || hit !== 1'b1 || sat !== 1'b0) begin
            failures++;
            $display("FAIL hit_values: got A=%0d B=%0d d=%0d hit=%b sat=%b need 16384 -163840 65536 1 0",
                     a_o, $signed(b_o), $signed(disc_o), hit, sat);
        end
        set_in(0, 0, 0, 0, 0, -16384, 49152, 0, -81920, 16384);
        do_run(lat);
        checks++;
        if ($signed(b_o) !== -64'sd163840 || $signed(disc_o) !== -64'sd524288 || hit !== 1'b0) begin
            failures++;
            $display("FAIL miss_values: got B=%0d d=%0d hit=%b need -163840 -524288 0",
                     $signed(b_o), $signed(disc_o), hit);
        end
        set_in(0, 0, 0, 0, 0, -16384, 16384, 0, -81920, 16384);
        do_run(lat);
        checks++;
        if (disc_o !== 64'd0 || hit !== 1'b1) begin
            failures++;
            $display("FAIL tangent: got d=%0d hit=%b need 0 1", $signed(disc_o), hit);
        end
        set_in(16384, 8192, 0, 11585, 5793, -11585, 49152, 16384, -32768, 40960);
        do_run(lat);
        dd = $signed(disc_o) - 64'sd444405;
        checks++;
        if ($signed({1'b0, a_o}) - 33'sd18432 > 4 || $signed({1'b0, a_o}) - 33'sd18432 < -4
            || $signed(b_o) + 64'sd98475 > 4 || $signed(b_o) + 64'sd98475 < -4
            || dd > 16 || dd < -16 || hit !== 1'b1) begin
            failures++;
            $display("FAIL diagonal_tol: got A=%0d B=%0d d=%0d hit=%b need ~18432 ~-98475 ~444405 1",
                     a_o, $signed(b_o), $signed(disc_o), hit);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] t;
        for (int i = 0; i < 24; i++) begin
            if (i < 12) begin
                set_in(int'($urandom_range(0, 2097152)) - 1048576, int'($urandom_range(0, 2097152)) - 1048576,
                       int'($urandom_range(0, 2097152)) - 1048576, int'($urandom_range(0, 32768)) - 16384,
                       int'($urandom_range(0, 32768)) - 16384, int'($urandom_range(0, 32768)) - 16384,
                       int'($urandom_range(0, 2097152)) - 1048576, int'($urandom_range(0, 2097152)) - 1048576,
                       int'($urandom_range(0, 2097152)) - 1048576, int'($urandom_range(0, 1048576)));
            end else begin
                t = $urandom;
                set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, int'(t & 32'h7FFF_FFFF));
            end
            model();
            do_run(lat);
            checks++;
            if (lat !== 15 || a_o !== exp_a || b_o !== exp_b || disc_o !== exp_d || hit !== exp_hit || sat !== exp_sat) begin
                failures++;
                $display("FAIL rand%0d: got lat=%0d A=%0d B=%0d d=%0d hit=%b sat=%b need 15 A=%0d B=%0d d=%0d hit=%b sat=%b",
                         i, lat, a_o, $signed(b_o), $signed(disc_o), hit, sat, exp_a, exp_b, exp_d, exp_hit, exp_sat);
            end
        end
    endtask

    task automatic test_ignore_start();
        int nv;
        set_in(0, 0, 0, 0, 0, -16384, 49152, 0, -81920, 16384);
        model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nv = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == 2 || cyc == 9);
            if (valid) nv++;
        end
        start = 1'b0;
        checks++;
        if (nv !== 1 || disc_o !== exp_d || hit !== exp_hit) begin
            failures++;
            $display("FAIL ignore_start: got valids=%0d d=%0d hit=%b need 1 %0d %b",
                     nv, $signed(disc_o), hit, exp_d, exp_hit);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        int at[4];
        set_in(0, 0, 0, 0, 0, -16384, 0, 0, -81920, 16384);
        model();
        nv = 0;
        at = '{0, 0, 0, 0};
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 39) start = 1'b0;
            if (valid) begin
                if (nv < 4) at[nv] = cyc;
                nv++;
                checks++;
                if (disc_o !== exp_d || a_o !== exp_a) begin
                    failures++;
                    $display("FAIL b2b_data%0d: got A=%0d d=%0d need %0d %0d",
                             nv, a_o, $signed(disc_o), exp_a, exp_d);
                end
            end
        end
        checks++;
        if (nv !== 3 || at[0] !== 15 || at[1] !== 31 || at[2] !== 47) begin
            failures++;
            $display("FAIL b2b_timing: got n=%0d at %0d %0d %0d need 3 at 15 31 47",
                     nv, at[0], at[1], at[2]);
        end
    endtask

    task automatic test_mid_reset();
        int nv;
        int lat;
        set_in(0, 0, 0, 0, 0, -16384, 0, 0, -81920, 16384);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, hit, sat, a_o, b_o, disc_o} !== '0) begin
            failures++;
            $display("FAIL mid_reset: got busy=%b A=%0d B=%0d d=%0d need all 0",
                     busy, a_o, $signed(b_o), $signed(disc_o));
        end
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        checks++;
        if (nv !== 0) begin
            failures++;
            $display("FAIL reset_no_valid: got %0d valids need 0", nv);
        end
        set_in(0, 0, 0, 0, 0, -16384, 0, 0, -81920, 16384);
        model();
        do_run(lat);
        checks++;
        if (lat !== 15 || disc_o !== exp_d || hit !== 1'b1) begin
            failures++;
            $display("FAIL after_reset: got lat=%0d d=%0d hit=%b need 15 %0d 1", lat, $signed(disc_o), hit, exp_d);
        end
    endtask

    task automatic test_overflow();
        int lat;
        set_in(0, 0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, 32'h7FFF_FFFF);
        model();
        do_run(lat);
        checks++;
        if (sat !== 1'b1 || disc_o !== 64'h7FFF_FFFF_FFFF_FFFF || a_o !== 32'h7FFF_FFFF || hit !== 1'b1) begin
            failures++;
            $display("FAIL overflow: got sat=%b d=%h A=%h hit=%b need 1 7fffffffffffffff 7fffffff 1",
                     sat, disc_o, a_o, hit);
        end
        checks++;
        if (b_o !== exp_b || disc_o !== exp_d || sat !== exp_sat) begin
            failures++;
            $display("FAIL overflow_model: got B=%0d d=%0d sat=%b need %0d %0d %b",
                     $signed(b_o), $signed(disc_o), sat, exp_b, exp_d, exp_sat);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (disc_o !== exp_d || sat !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold: got d=%0d sat=%b busy=%b need %0d 1 0", $signed(disc_o), sat, busy, exp_d);
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_directed();
        test_spec_values();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
